// File: rtl/clkrx.sv
// clkrx: synchronizes an external serial clock/data pair into clk_i, assembles MSB-first words
// on each return-to-idle sclk edge, and flags short half-periods and frames ended by idle timeout.
module clkrx #(
  parameter int WIDTH     = 8,
  parameter int IDLE_HIGH = 1,
  parameter int MIN_HALF  = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sclk_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             active_o,
  output logic             err_short_o,
  output logic             err_frame_o
);

  if (WIDTH < 1 || MIN_HALF < 1 || TIMEOUT <= MIN_HALF || (IDLE_HIGH != 0 && IDLE_HIGH != 1))
  begin : g_bad_param
    $error("clkrx: illegal parameter combination");
  end

  localparam logic IDLE_LVL = (IDLE_HIGH != 0);
  localparam int   WCNT_W   = $clog2(TIMEOUT + 1);
  localparam int   BCNT_W   = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  state_e              state_q, state_d;
  logic                sclk_meta_q, sclk_meta_d;
  logic                sclk_s_q, sclk_s_d;
  logic                sclk_q, sclk_d;
  logic                sdata_meta_q, sdata_meta_d;
  logic                sdata_s_q, sdata_s_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_short_q, err_short_d;
  logic                err_frame_q, err_frame_d;

  logic edge_det, leave, capture, is_short, timed_out;

  always_comb begin
    sclk_meta_d  = sclk_i;
    sclk_s_d     = sclk_meta_q;
    sclk_d       = sclk_s_q;
    sdata_meta_d = sdata_i;
    sdata_s_d    = sdata_meta_q;

    edge_det  = (sclk_s_q != sclk_q);
    leave     = edge_det && (sclk_s_q != IDLE_LVL);
    capture   = edge_det && (sclk_s_q == IDLE_LVL);
    // wcnt counts completed cycles of the current level minus one
    is_short  = (wcnt_q < WCNT_W'(MIN_HALF - 1));
    timed_out = (wcnt_q == WCNT_W'(TIMEOUT));

    if (edge_det)       wcnt_d = '0;
    else if (timed_out) wcnt_d = wcnt_q;
    else                wcnt_d = wcnt_q + WCNT_W'(1);

    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_short_d = 1'b0;
    err_frame_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        bcnt_d  = '0;
        shift_d = '0;
        if (leave) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (edge_det && is_short) err_short_d = 1'b1;
        if (capture) begin
          // bit k of the frame lands at position WIDTH-1-k, i.e. MSB first
          for (int i = 0; i < WIDTH; i++) begin
            if (BCNT_W'(WIDTH - 1 - i) == bcnt_q) shift_d[i] = sdata_s_q;
          end
          if (bcnt_q == BCNT_W'(WIDTH - 1)) begin
            data_d  = shift_d;
            valid_d = 1'b1;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else if (timed_out) begin
          state_d     = S_IDLE;
          err_frame_d = (bcnt_q != '0) || (sclk_s_q != IDLE_LVL);
          bcnt_d      = '0;
          shift_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      sclk_meta_q  <= IDLE_LVL;
      sclk_s_q     <= IDLE_LVL;
      sclk_q       <= IDLE_LVL;
      sdata_meta_q <= 1'b0;
      sdata_s_q    <= 1'b0;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      err_short_q  <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_meta_q  <= sclk_meta_d;
      sclk_s_q     <= sclk_s_d;
      sclk_q       <= sclk_d;
      sdata_meta_q <= sdata_meta_d;
      sdata_s_q    <= sdata_s_d;
      wcnt_q       <= wcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      err_short_q  <= err_short_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign active_o    = (state_q == S_ACTIVE);
  assign err_short_o = err_short_q;
  assign err_frame_o = err_frame_q;

endmodule

// File: tb/tb_clkrx.sv
// Directed bench for clkrx: vector table of words/partial words plus hand-written
// back-to-back, stuck-clock and mid-word reset sequences.
module tb_clkrx;
  localparam int HALF = 4;
  localparam int TO   = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       sclk_i;
  logic       sdata_i;
  logic [7:0] data_o;
  logic       valid_o, active_o, err_short_o, err_frame_o;

  always #5 clk_i = ~clk_i;

  clkrx #(.WIDTH(8), .IDLE_HIGH(1), .MIN_HALF(4), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sclk_i(sclk_i), .sdata_i(sdata_i),
    .data_o(data_o), .valid_o(valid_o), .active_o(active_o),
    .err_short_o(err_short_o), .err_frame_o(err_frame_o)
  );

  // cycle stamp and event monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int         n_valid = 0, n_short = 0, n_frame = 0, n_both = 0, n_inact = 0;
  int         fcyc = 0;
  logic       fact = 1'b0;
  logic [7:0] vdata[$];
  int         vcyc[$];

  always @(negedge clk_i) begin
    if (valid_o) begin
      n_valid <= n_valid + 1;
      vdata.push_back(data_o);
      vcyc.push_back(cyc);
    end
    if (err_short_o) n_short <= n_short + 1;
    if (valid_o && err_short_o) n_both <= n_both + 1;
    if (err_frame_o) begin
      n_frame <= n_frame + 1;
      fcyc    <= cyc;
      fact    <= active_o;
    end
    if (!active_o) n_inact <= n_inact + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  int last_edge = 0;

  // each bit: falling edge with new data, low phase, rising (capture) edge, high phase
  task automatic send_bits(input logic [7:0] w, input int nbits, input int short_bit);
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      sclk_i    = 1'b0;
      sdata_i   = w[i];
      last_edge = cyc;
      tick((i == short_bit) ? 2 : HALF);
      sclk_i    = 1'b1;
      last_edge = cyc;
      tick(HALF);
    end
  endtask

  typedef struct {
    logic [7:0] word;
    int         nbits;
    int         short_bit;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_short;
    int         exp_frame;
    int         exp_both;
  } vec_t;

  vec_t vecs[7];
  int   s_valid, s_short, s_frame, s_both, s_inact, lat;

  initial begin : main
    vecs[0] = '{8'hA5, 8, -1, 8'hA5, 1, 0, 0, 0};
    vecs[1] = '{8'h3C, 8,  2, 8'h3C, 1, 1, 0, 0};
    vecs[2] = '{8'hF0, 5, -1, 8'h3C, 0, 0, 1, 0};
    vecs[3] = '{8'h81, 8, -1, 8'h81, 1, 0, 0, 0};
    vecs[4] = '{8'hFF, 8,  7, 8'hFF, 1, 1, 0, 0};
    vecs[5] = '{8'h00, 8,  0, 8'h00, 1, 1, 0, 1};
    vecs[6] = '{8'h80, 1, -1, 8'h00, 0, 0, 1, 0};

    rst_ni  = 1'b1;
    sclk_i  = 1'b1;
    sdata_i = 1'b0;
    #2 rst_ni = 1'b0;
    tick(3);
    chk("reset data_o", int'(data_o), 0);
    chk("reset flags", int'({valid_o, active_o, err_short_o, err_frame_o}), 0);
    rst_ni = 1'b1;
    tick(5);

    for (int v = 0; v < 7; v++) begin
      s_valid = n_valid; s_short = n_short; s_frame = n_frame; s_both = n_both;
      send_bits(vecs[v].word, vecs[v].nbits, vecs[v].short_bit);
      tick(TO + 10);
      chk($sformatf("v%0d data_o", v), int'(data_o), int'(vecs[v].exp_data));
      chk($sformatf("v%0d valid pulses", v), n_valid - s_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d short pulses", v), n_short - s_short, vecs[v].exp_short);
      chk($sformatf("v%0d frame pulses", v), n_frame - s_frame, vecs[v].exp_frame);
      chk($sformatf("v%0d valid+short", v), n_both - s_both, vecs[v].exp_both);
      chk($sformatf("v%0d active after idle", v), int'(active_o), 0);
      if (vecs[v].exp_valid == 1 && n_valid > s_valid) begin
        chk($sformatf("v%0d word", v), int'(vdata[s_valid]), int'(vecs[v].exp_data));
        lat = vcyc[s_valid] - last_edge;
        chk($sformatf("v%0d latency %0d in 3..5", v, lat), int'(lat >= 3 && lat <= 5), 1);
      end
      if (vecs[v].exp_frame == 1 && n_frame > s_frame) begin
        chk($sformatf("v%0d timeout delay", v), fcyc - last_edge, TO + 4);
        chk($sformatf("v%0d active at frame err", v), int'(fact), 0);
      end
    end

    // back-to-back words with no idle gap
    s_valid = n_valid; s_frame = n_frame;
    send_bits(8'h3C, 8, -1);
    s_inact = n_inact;
    send_bits(8'hC3, 8, -1);
    chk("b2b active held", n_inact - s_inact, 0);
    tick(TO + 10);
    chk("b2b valid pulses", n_valid - s_valid, 2);
    chk("b2b no frame err", n_frame - s_frame, 0);
    if (n_valid - s_valid == 2) begin
      chk("b2b word0", int'(vdata[s_valid]), 'h3C);
      chk("b2b word1", int'(vdata[s_valid+1]), 'hC3);
      chk("b2b spacing", vcyc[s_valid+1] - vcyc[s_valid], 16 * HALF);
    end

    // clock stuck low
    s_valid = n_valid; s_frame = n_frame;
    sclk_i    = 1'b0;
    last_edge = cyc;
    tick(40);
    chk("stuck frame err", n_frame - s_frame, 1);
    chk("stuck timeout delay", fcyc - last_edge, TO + 4);
    chk("stuck active", int'(active_o), 0);
    sclk_i = 1'b1;
    tick(10);
    chk("stuck rise ignored", int'(active_o), 0);
    send_bits(8'h96, 8, -1);
    tick(TO + 10);
    chk("stuck recover data", int'(data_o), 'h96);
    chk("stuck recover valid", n_valid - s_valid, 1);
    chk("stuck no extra frame", n_frame - s_frame, 1);

    // asynchronous reset after three bits
    s_valid = n_valid; s_frame = n_frame; s_short = n_short;
    send_bits(8'hFF, 3, -1);
    chk("mid-word active", int'(active_o), 1);
    #3 rst_ni = 1'b0;
    #1;
    chk("async reset data_o", int'(data_o), 0);
    chk("async reset flags", int'({valid_o, active_o, err_short_o, err_frame_o}), 0);
    tick(3);
    rst_ni = 1'b1;
    tick(TO + 10);
    chk("post-reset pulses", (n_valid - s_valid) + (n_frame - s_frame) + (n_short - s_short), 0);
    chk("post-reset idle", int'(active_o), 0);
    send_bits(8'h5A, 8, -1);
    tick(TO + 10);
    chk("post-reset data", int'(data_o), 'h5A);
    chk("post-reset valid", n_valid - s_valid, 1);
    chk("post-reset frame", n_frame - s_frame, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
